weyl_sng_stream: RTL and testbench

// Multi-channel stochastic number generator (SNG) that converts per-channel quotas into serial unary bitstreams.

---
 rtl/weyl_sng_stream.sv | 195 +++++++++++++++++++
 tb/tb_weyl_sng_stream.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/weyl_sng_stream.sv
// weyl_sng_stream: multi-channel Weyl-sequenced stochastic number generator.
// Optional macro WEYL_SNG_ONES_CHECK_EN adds per-channel ones audit (err_ones).
module weyl_sng_stream #(
    parameter int LEN       = 64,
    parameter int BASE      = 61,
    parameter int STRIDE    = 17,
    parameter int CHANNELS  = 4,
    parameter int CH_OFFSET = 23,
    localparam int QW       = $clog2(LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CHANNELS*QW-1:0] cfg_quota,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHANNELS-1:0]    out_bits,
    output logic                   out_last,
`ifdef WEYL_SNG_ONES_CHECK_EN
    output logic [CHANNELS-1:0]    err_ones,
`endif
    output logic                   busy
);

    localparam int PW   = $clog2(LEN) + 1;
    localparam int CW   = $clog2(LEN);
    localparam int STEP = STRIDE % LEN;

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    if (gcd(STEP, LEN) != 1) begin : g_bad_stride
        $error("weyl_sng_stream: STRIDE %% LEN must be coprime with LEN");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   phase_q [CHANNELS];
    logic [QW-1:0]   quota_q [CHANNELS];
    logic [CW-1:0]   cnt_q;

    logic [PW-1:0]   phase0  [CHANNELS];
    logic [PW-1:0]   sum_c   [CHANNELS];
    logic [PW-1:0]   phase_d [CHANNELS];
    logic [QW-1:0]   quota_d [CHANNELS];

    logic run;
    logic accept;
    logic xfer;

    // Initial Weyl phases are elaboration constants, one per channel
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ph0
        assign phase0[g] = PW'((BASE + g * CH_OFFSET) % LEN);
    end

    assign run       = (state_q == RUN);
    assign cfg_ready = (state_q == IDLE);
    assign out_valid = run;
    assign busy      = run;
    assign accept    = cfg_valid && cfg_ready;
    assign xfer      = run && out_ready;
    assign out_last  = run && (cnt_q == CW'(LEN - 1));

    // Next Weyl phase: add the reduced stride, fold back once into 0..LEN-1
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum_c[c] = phase_q[c] + PW'(STEP);
            if (sum_c[c] >= PW'(LEN)) begin
                phase_d[c] = sum_c[c] - PW'(LEN);
            end else begin
                phase_d[c] = sum_c[c];
            end
        end
    end

    // Saturate incoming quotas to LEN so quota>=LEN means all ones
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_quota[c*QW +: QW] > QW'(LEN)) begin
                quota_d[c] = QW'(LEN);
            end else begin
                quota_d[c] = cfg_quota[c*QW +: QW];
            end
        end
    end

    // Stochastic bit per channel, decoded purely from registered state
    always_comb begin
        out_bits = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_bits[c] = run && (phase_q[c] < PW'(quota_q[c]));
        end
    end

    // Control FSM with phase, quota and beat counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                phase_q[c] <= '0;
                quota_q[c] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            phase_q[c] <= phase0[c];
                            quota_q[c] <= quota_d[c];
                        end
                    end
                end
                RUN: begin
                    if (abort || (out_ready && out_last)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            phase_q[c] <= '0;
                        end
                    end else if (out_ready) begin
                        cnt_q <= cnt_q + CW'(1);
                        for (int c = 0; c < CHANNELS; c++) begin
                            phase_q[c] <= phase_d[c];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WEYL_SNG_ONES_CHECK_EN
    logic [QW-1:0]       ones_q [CHANNELS];
    logic [QW-1:0]       ones_d [CHANNELS];
    logic [CHANNELS-1:0] err_q;

    // Running ones count including the beat currently on the bus
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ones_d[c] = ones_q[c] + QW'(out_bits[c]);
        end
    end

    // Ones audit: count transferred ones, flag sticky mismatch at stream end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                ones_q[c] <= '0;
            end
        end else if (accept) begin
            err_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                ones_q[c] <= '0;
            end
        end else if (run && abort) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ones_q[c] <= '0;
            end
        end else if (xfer) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ones_q[c] <= ones_d[c];
                if (out_last && (ones_d[c] != quota_q[c])) begin
                    err_q[c] <= 1'b1;
                end
            end
        end
    end

    assign err_ones = err_q;
`endif

endmodule

// File: tb/tb_weyl_sng_stream.sv
// tb_weyl_sng_stream: directed self-checking bench for weyl_sng_stream.
// Expected bitstreams come from hand constants and a mod-LEN phase model.
module tb_weyl_sng_stream;

    localparam int LEN = 64;
    localparam int CH  = 4;
    localparam int QW  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_valid = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;
    logic [CH*QW-1:0] cfg_quota = '0;
    logic cfg_ready;
    logic out_valid;
    logic out_last;
    logic busy;
    logic [CH-1:0] out_bits;
`ifdef WEYL_SNG_ONES_CHECK_EN
    logic [CH-1:0] err_ones;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int ones [CH];
    int qsat [CH];
    int ph [CH];
    int ph0 [CH] = '{61, 20, 43, 2};
    int last_seen;
    int beat3;
    logic [CH-1:0] hist [LEN];

    weyl_sng_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_quota (cfg_quota),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_last  (out_last),
`ifdef WEYL_SNG_ONES_CHECK_EN
        .err_ones  (err_ones),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_bits"}, 64'(out_bits), 64'(0));
        chk({tag, "_last"}, 64'(out_last), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'(1));
    endtask

    task automatic load(input int q0, input int q1, input int q2,
                        input int q3, input logic ab);
        int q [CH];
        q = '{q0, q1, q2, q3};
        for (int c = 0; c < CH; c++) begin
            qsat[c] = (q[c] > LEN) ? LEN : q[c];
            cfg_quota[c*QW +: QW] = QW'(q[c]);
        end
        chk("cfg_ready_pre", 64'(cfg_ready), 64'(1));
        cfg_valid = 1'b1;
        abort = ab;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        abort = 1'b0;
        chk("acc_valid", 64'(out_valid), 64'(1));
        chk("acc_busy", 64'(busy), 64'(1));
        chk("acc_cfg_ready", 64'(cfg_ready), 64'(0));
    endtask

    task automatic run(input bit rnd, input int stop);
        int beat;
        int cyc;
        logic rdy;
        logic [CH-1:0] pb;
        logic pl;
        logic [CH-1:0] eb;
        beat = 0;
        cyc = 0;
        last_seen = 0;
        beat3 = -1;
        for (int c = 0; c < CH; c++) begin
            ones[c] = 0;
            ph[c] = ph0[c];
        end
        while (beat < stop && cyc < 2000) begin
            for (int c = 0; c < CH; c++) begin
                eb[c] = (ph[c] < qsat[c]);
            end
            chk("beat_valid", 64'(out_valid), 64'(1));
            chk("beat_bits", 64'(out_bits), 64'(eb));
            chk("beat_last", 64'(out_last), 64'(beat == LEN - 1));
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            pb = out_bits;
            pl = out_last;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                hist[beat] = pb;
                for (int c = 0; c < CH; c++) begin
                    if (pb[c]) ones[c]++;
                    ph[c] = (ph[c] + 17) % LEN;
                end
                if (pb[3]) beat3 = beat;
                if (pl) last_seen++;
                beat++;
            end else begin
                chk("stall_bits", 64'(out_bits), 64'(pb));
                chk("stall_last", 64'(out_last), 64'(pl));
            end
        end
        out_ready = 1'b1;
        chk("beats_done", 64'(beat), 64'(stop));
    endtask

    task automatic chk_ones(input int e0, input int e1, input int e2,
                            input int e3);
        chk("ones_ch0", 64'(ones[0]), 64'(e0));
        chk("ones_ch1", 64'(ones[1]), 64'(e1));
        chk("ones_ch2", 64'(ones[2]), 64'(e2));
        chk("ones_ch3", 64'(ones[3]), 64'(e3));
    endtask

    initial begin
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("post_rst");

        load(20, 5, 40, 63, 1'b0);
        run(1'b0, LEN);
        chk_ones(20, 5, 40, 63);
        chk("beat0_bit0", 64'(hist[0][0]), 64'(0));
        chk("beat1_bit0", 64'(hist[1][0]), 64'(1));
        chk("last_once", 64'(last_seen), 64'(1));
        chk_reset_vals("end1");
`ifdef WEYL_SNG_ONES_CHECK_EN
        chk("err_ones_clean", 64'(err_ones), 64'(0));
`endif

        load(0, 64, 100, 1, 1'b0);
        run(1'b0, LEN);
        chk_ones(0, 64, 64, 1);
        chk("ch3_one_beat", 64'(beat3), 64'(30));
        chk_reset_vals("end2");

        load(33, 33, 33, 33, 1'b0);
        run(1'b1, LEN);
        chk_ones(33, 33, 33, 33);
        chk("rnd_last_once", 64'(last_seen), 64'(1));
        chk_reset_vals("end3");

        load(20, 5, 40, 63, 1'b0);
        run(1'b0, 10);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_reset_vals("abort");
        load(20, 5, 40, 63, 1'b1);
        run(1'b0, LEN);
        chk_ones(20, 5, 40, 63);
        chk_reset_vals("end4");

        load(7, 50, 64, 12, 1'b0);
        run(1'b0, 30);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        chk("mid_rst_no_last", 64'(last_seen), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
